// File: rtl/rbm_vote_scheduler.sv
// Vote scheduler for repeated stochastic RBM inference passes: drives the layer chain,
// accumulates per-class votes, and picks the winner by count limit or by leader margin.

module rbm_vote_ctr #(
  parameter int unsigned count_bitlength = 12
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_clr,
  input  logic                       i_inc,
  output logic [count_bitlength-1:0] o_cnt
);
  logic [count_bitlength-1:0] r_cnt;

  // Saturate at all-ones so a long run never wraps a leader back to zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                      r_cnt <= '0;
    else if (i_clr)                 r_cnt <= '0;
    else if (i_inc && r_cnt != '1)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

module rbm_vote_scheduler #(
  parameter int unsigned output_dim      = 10,
  parameter int unsigned count_bitlength = 12,
  parameter int unsigned idx_bitlength   = 4,
  parameter int unsigned iteration_num   = 100,
  parameter int unsigned min_iterations  = 10,
  parameter int unsigned margin          = 20
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic                                  layer_reset,
  output logic                                  layer_start,
  input  logic                                  layer_finish,
  input  logic [output_dim-1:0]                 layer_votes,
  output logic [output_dim*count_bitlength-1:0] vote_counts,
  output logic [idx_bitlength-1:0]              class_idx,
  output logic [9:0]                            iterations_done,
  output logic                                  early_exit,
  output logic                                  out_valid,
  input  logic                                  out_ready
);
  typedef enum logic [2:0] {S_IDLE, S_LRST, S_RUN, S_ACCUM, S_SCAN, S_DECIDE, S_DONE} state_t;

  state_t                                       r_state, w_state_nxt;
  logic [output_dim-1:0]                        r_votes;
  logic [output_dim-1:0][count_bitlength-1:0]   w_counts;
  logic [idx_bitlength-1:0]                     r_scan_idx, r_top_idx, r_class;
  logic [count_bitlength-1:0]                   r_top, r_second, w_scan_val;
  logic [9:0]                                   r_iters;
  logic                                         r_early, r_in_ready, r_layer_reset, r_layer_start, r_out_valid;
  logic                                         w_accept, w_scan_last, w_last_iter, w_margin_hit;

  assign w_accept    = (r_state == S_IDLE) && in_valid;
  assign w_scan_last = (r_scan_idx == idx_bitlength'(output_dim - 1));
  assign w_last_iter = (r_iters == 10'(iteration_num));
  assign w_margin_hit = (margin != 0) && (r_iters >= 10'(min_iterations)) &&
                        (32'(r_top - r_second) >= margin);

  genvar g;
  generate
    for (g = 0; g < output_dim; g++) begin : g_lane
      rbm_vote_ctr #(.count_bitlength(count_bitlength)) u_ctr (
        .clock (clock),
        .reset (reset),
        .i_clr (w_accept),
        .i_inc ((r_state == S_ACCUM) && r_votes[g]),
        .o_cnt (w_counts[g])
      );
    end
  endgenerate

  always_comb begin
    w_scan_val = '0;
    for (int i = 0; i < output_dim; i++)
      if (r_scan_idx == idx_bitlength'(i)) w_scan_val = w_counts[i];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (in_valid)     w_state_nxt = S_LRST;
      S_LRST:                     w_state_nxt = S_RUN;
      S_RUN:    if (layer_finish) w_state_nxt = S_ACCUM;
      S_ACCUM:                    w_state_nxt = S_SCAN;
      S_SCAN:   if (w_scan_last)  w_state_nxt = S_DECIDE;
      S_DECIDE: w_state_nxt = (w_last_iter || w_margin_hit) ? S_DONE : S_LRST;
      S_DONE:   if (out_ready)    w_state_nxt = S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake/control outputs are registered off the next state so they line up with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_in_ready    <= 1'b1;
      r_layer_reset <= 1'b1;
      r_layer_start <= 1'b0;
      r_out_valid   <= 1'b0;
    end else begin
      r_in_ready    <= (w_state_nxt == S_IDLE);
      r_layer_reset <= (w_state_nxt != S_RUN);
      r_layer_start <= (w_state_nxt == S_RUN);
      r_out_valid   <= (w_state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_votes    <= '0;
      r_iters    <= '0;
      r_early    <= 1'b0;
      r_class    <= '0;
      r_scan_idx <= '0;
      r_top      <= '0;
      r_top_idx  <= '0;
      r_second   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_accept) begin
          r_iters <= '0;
          r_early <= 1'b0;
          r_class <= '0;
        end
        S_RUN: if (layer_finish) r_votes <= layer_votes;
        S_ACCUM: begin
          r_iters    <= r_iters + 10'd1;
          r_scan_idx <= '0;
        end
        S_SCAN: begin
          r_scan_idx <= r_scan_idx + 1'b1;
          if (r_scan_idx == '0) begin
            r_top     <= w_scan_val;
            r_top_idx <= '0;
            r_second  <= '0;
          end else if (w_scan_val > r_top) begin
            r_second  <= r_top;
            r_top     <= w_scan_val;
            r_top_idx <= r_scan_idx;
          end else if (w_scan_val > r_second) begin
            // An equal-to-top value lands here: lower index wins, margin collapses to 0.
            r_second  <= w_scan_val;
          end
        end
        S_DECIDE: begin
          r_class <= r_top_idx;
          r_early <= !w_last_iter && w_margin_hit;
        end
        default: ;
      endcase
    end
  end

  assign in_ready        = r_in_ready;
  assign layer_reset     = r_layer_reset;
  assign layer_start     = r_layer_start;
  assign out_valid       = r_out_valid;
  assign vote_counts     = w_counts;
  assign class_idx       = r_class;
  assign iterations_done = r_iters;
  assign early_exit      = r_early;
endmodule

// File: tb/tb_rbm_vote_scheduler.sv
// Bench for rbm_vote_scheduler: four parameter sets, a vector table, random runs
// against a pass-by-pass vote model, and hand sequences for reset abort and DONE hold.

module tb_rbm_vote_scheduler;
  localparam int LAT = 10;

  logic        clock = 1'b0, reset = 1'b1;
  logic [3:0]  in_valid = '0, out_ready = '0, layer_finish = '0;
  logic [3:0]  in_ready, layer_reset, layer_start, early_exit, out_valid;
  logic [3:0]  lv   [4];
  logic [3:0]  cls  [4];
  logic [9:0]  itd  [4];
  logic [47:0] vc   [3];
  logic [11:0] vc_d;

  int n_chk = 0, n_err = 0;
  int P_ITER[4]   = '{5, 20, 4, 10};
  int P_MIN[4]    = '{10, 2, 10, 10};
  int P_MARGIN[4] = '{0, 3, 0, 0};
  int P_MAX[4]    = '{4095, 4095, 4095, 7};

  always #5 clock = ~clock;

  rbm_vote_scheduler #(.output_dim(4), .count_bitlength(12), .idx_bitlength(4),
    .iteration_num(5), .min_iterations(10), .margin(0)) u_a (
    .clock(clock), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .layer_reset(layer_reset[0]), .layer_start(layer_start[0]), .layer_finish(layer_finish[0]),
    .layer_votes(lv[0]), .vote_counts(vc[0]), .class_idx(cls[0]), .iterations_done(itd[0]),
    .early_exit(early_exit[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]));

  rbm_vote_scheduler #(.output_dim(4), .count_bitlength(12), .idx_bitlength(4),
    .iteration_num(20), .min_iterations(2), .margin(3)) u_b (
    .clock(clock), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .layer_reset(layer_reset[1]), .layer_start(layer_start[1]), .layer_finish(layer_finish[1]),
    .layer_votes(lv[1]), .vote_counts(vc[1]), .class_idx(cls[1]), .iterations_done(itd[1]),
    .early_exit(early_exit[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]));

  rbm_vote_scheduler #(.output_dim(4), .count_bitlength(12), .idx_bitlength(4),
    .iteration_num(4), .min_iterations(10), .margin(0)) u_c (
    .clock(clock), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .layer_reset(layer_reset[2]), .layer_start(layer_start[2]), .layer_finish(layer_finish[2]),
    .layer_votes(lv[2]), .vote_counts(vc[2]), .class_idx(cls[2]), .iterations_done(itd[2]),
    .early_exit(early_exit[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]));

  rbm_vote_scheduler #(.output_dim(4), .count_bitlength(3), .idx_bitlength(4),
    .iteration_num(10), .min_iterations(10), .margin(0)) u_d (
    .clock(clock), .reset(reset), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .layer_reset(layer_reset[3]), .layer_start(layer_start[3]), .layer_finish(layer_finish[3]),
    .layer_votes(lv[3]), .vote_counts(vc_d), .class_idx(cls[3]), .iterations_done(itd[3]),
    .early_exit(early_exit[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]));

  typedef struct {
    int d; logic [3:0] v0, v1; int c0, c1, c2, c3, cl, it; bit ee;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int getcnt(input int d, input int i);
    if (d == 3) return int'(vc_d[i*3 +: 3]);
    return int'(vc[d][i*12 +: 12]);
  endfunction

  // Reference: replay the vote sequence pass by pass with saturating integer counters.
  function automatic void model(input int d, input logic [3:0] vq[$],
                                output int ec[4], output int ecl, output int eit, output bit eee);
    int top, sec;
    for (int i = 0; i < 4; i++) ec[i] = 0;
    ecl = 0; eit = 0; eee = 0;
    for (int p = 1; p <= P_ITER[d]; p++) begin
      for (int i = 0; i < 4; i++)
        if (vq[(p-1) % vq.size()][i]) ec[i] = (ec[i] + 1 > P_MAX[d]) ? P_MAX[d] : ec[i] + 1;
      top = -1;
      for (int i = 0; i < 4; i++) if (ec[i] > top) begin top = ec[i]; ecl = i; end
      sec = 0;
      for (int i = 0; i < 4; i++) if (i != ecl && ec[i] > sec) sec = ec[i];
      eit = p;
      if (p == P_ITER[d]) return;
      if (P_MARGIN[d] != 0 && p >= P_MIN[d] && top - sec >= P_MARGIN[d]) begin eee = 1; return; end
    end
  endfunction

  // Accept a sample and play layer chain: finish LAT cycles into each RUN with the next vote word.
  task automatic run_sample(input int d, input logic [3:0] vq[$], input int abort_at);
    int cnt = 0, p = 0;
    @(negedge clock); in_valid[d] = 1'b1;
    @(negedge clock); in_valid[d] = 1'b0;
    chk($sformatf("accept%0d", d), int'(in_ready[d]), 0);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (out_valid[d]) return;
      if (abort_at > 0 && int'(itd[d]) == abort_at && layer_start[d]) begin
        layer_finish[d] = 1'b0;
        return;
      end
      if (layer_start[d]) begin
        cnt++;
        if (cnt == LAT) begin
          layer_finish[d] = 1'b1; lv[d] = vq[p % vq.size()]; p++;
        end else layer_finish[d] = 1'b0;
      end else begin
        cnt = 0; layer_finish[d] = 1'b0;
      end
      @(negedge clock);
    end
    layer_finish[d] = 1'b0;
    chk($sformatf("timeout%0d", d), 1, 0);
  endtask

  task automatic chk_res(input string nm, input int d, input int ec[4],
                         input int ecl, input int eit, input bit eee);
    chk({nm, ".out_valid"}, int'(out_valid[d]), 1);
    for (int i = 0; i < 4; i++) chk($sformatf("%s.cnt%0d", nm, i), getcnt(d, i), ec[i]);
    chk({nm, ".class"}, int'(cls[d]), ecl);
    chk({nm, ".iters"}, int'(itd[d]), eit);
    chk({nm, ".early"}, int'(early_exit[d]), int'(eee));
  endtask

  task automatic release_out(input int d);
    out_ready[d] = 1'b1;
    @(negedge clock);
    out_ready[d] = 1'b0;
    chk($sformatf("rel%0d.out_valid", d), int'(out_valid[d]), 0);
    chk($sformatf("rel%0d.in_ready", d), int'(in_ready[d]), 1);
  endtask

  initial begin
    vec_t tbl[4];
    logic [3:0] vq[$];
    int ec[4], ecl, eit, snap[4], s_cls, s_it, s_ee;
    bit eee;

    for (int d = 0; d < 4; d++) lv[d] = '0;
    tbl[0] = '{0, 4'b0100, 4'b0100, 0, 0, 5, 0, 2, 5, 1'b0};
    tbl[1] = '{1, 4'b0001, 4'b0001, 3, 0, 0, 0, 0, 3, 1'b1};
    tbl[2] = '{2, 4'b1000, 4'b0010, 0, 2, 0, 2, 1, 4, 1'b0};
    tbl[3] = '{3, 4'b1111, 4'b1111, 7, 7, 7, 7, 0, 10, 1'b0};

    repeat (3) @(negedge clock);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst%0d.in_ready", d), int'(in_ready[d]), 1);
      chk($sformatf("rst%0d.layer_reset", d), int'(layer_reset[d]), 1);
      chk($sformatf("rst%0d.layer_start", d), int'(layer_start[d]), 0);
      chk($sformatf("rst%0d.out_valid", d), int'(out_valid[d]), 0);
      chk($sformatf("rst%0d.iters", d), int'(itd[d]), 0);
      chk($sformatf("rst%0d.cnt0", d), getcnt(d, 0), 0);
    end
    reset = 1'b0;

    foreach (tbl[k]) begin
      vq = {}; vq.push_back(tbl[k].v0); vq.push_back(tbl[k].v1);
      run_sample(tbl[k].d, vq, 0);
      ec = '{tbl[k].c0, tbl[k].c1, tbl[k].c2, tbl[k].c3};
      chk_res($sformatf("vec%0d", k), tbl[k].d, ec, tbl[k].cl, tbl[k].it, tbl[k].ee);
      release_out(tbl[k].d);
    end

    for (int r = 0; r < 12; r++) begin
      int d = (r < 8) ? 1 : 0;
      int fav = $urandom_range(0, 3);
      vq = {};
      for (int p = 0; p < 20; p++) begin
        logic [3:0] v = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 2) != 0) v[fav] = 1'b1;
        vq.push_back(v);
      end
      model(d, vq, ec, ecl, eit, eee);
      run_sample(d, vq, 0);
      chk_res($sformatf("rnd%0d", r), d, ec, ecl, eit, eee);
      release_out(d);
    end

    vq = {}; vq.push_back(4'b0100);
    run_sample(0, vq, 2);
    reset = 1'b1;
    #1;
    chk("abort.in_ready", int'(in_ready[0]), 1);
    chk("abort.layer_reset", int'(layer_reset[0]), 1);
    chk("abort.layer_start", int'(layer_start[0]), 0);
    chk("abort.cnt2", getcnt(0, 2), 0);
    chk("abort.iters", int'(itd[0]), 0);
    chk("abort.class", int'(cls[0]), 0);
    @(negedge clock); reset = 1'b0;
    vq = {}; vq.push_back(4'b0001);
    run_sample(0, vq, 0);
    chk_res("after_abort", 0, '{5, 0, 0, 0}, 0, 5, 1'b0);

    for (int i = 0; i < 4; i++) snap[i] = getcnt(0, i);
    s_cls = int'(cls[0]); s_it = int'(itd[0]); s_ee = int'(early_exit[0]);
    in_valid[0] = 1'b1;
    for (int c = 0; c < 50; c++) begin
      layer_finish[0] = (c == 10); lv[0] = 4'b1111;
      @(negedge clock);
      chk("hold.out_valid", int'(out_valid[0]), 1);
      chk("hold.in_ready", int'(in_ready[0]), 0);
    end
    layer_finish[0] = 1'b0;
    for (int i = 0; i < 4; i++) chk($sformatf("hold.cnt%0d", i), getcnt(0, i), snap[i]);
    chk("hold.class", int'(cls[0]), s_cls);
    chk("hold.iters", int'(itd[0]), s_it);
    chk("hold.early", int'(early_exit[0]), s_ee);
    in_valid[0] = 1'b0;
    release_out(0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
